uart_tx_scheduler: RTL and testbench

Packet scheduler that shares the single RS-232 transmit path between up to eight on-board byte streams. Each requester hands over a whole packet; the block grants sources round-robin, frames every packet with a source-tagged header byte and an XOR checksum byte, and stages the result in a small output FIFO. The output side presents the same FIFO-style byte interface the UART encoder already reads (`tx_buffer_empty`, `tx_buffer_byte`, `tx_buffer_read_enable`).

---
 rtl/uart_tx_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin packet framer in front of the UART transmit FIFO.
// Each granted source's packet is emitted as: header (HEADER_BASE | source),
// payload bytes, then an XOR checksum of the payload. Bytes are staged in a
// small non-show-ahead FIFO read by the UART encoder.
module uart_tx_scheduler #(
    parameter int          NUM_SOURCES = 4,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [7:0]  HEADER_BASE = 8'hA0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SOURCES-1:0]     src_valid,
    input  logic [8*NUM_SOURCES-1:0]   src_byte,
    input  logic [NUM_SOURCES-1:0]     src_last,
    output logic [NUM_SOURCES-1:0]     src_ready,
    input  logic                       tx_buffer_read_enable,
    output logic                       tx_buffer_empty,
    output logic [7:0]                 tx_buffer_byte,
    output logic                       busy,
    output logic [2:0]                 active_source
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HEADER   = 2'd1;
    localparam logic [1:0] ST_PAYLOAD  = 2'd2;
    localparam logic [1:0] ST_CHECKSUM = 2'd3;

    // Lanes padded out to eight so the granted lane can be selected by a 3-bit index.
    logic [7:0] valid_pad;
    logic [7:0] last_pad;
    logic [7:0] lane_byte [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            if (gi < NUM_SOURCES) begin : g_used
                assign valid_pad[gi] = src_valid[gi];
                assign last_pad[gi]  = src_last[gi];
                assign lane_byte[gi] = src_byte[8*gi +: 8];
            end else begin : g_unused
                assign valid_pad[gi] = 1'b0;
                assign last_pad[gi]  = 1'b0;
                assign lane_byte[gi] = 8'h00;
            end
        end
    endgenerate

    logic [1:0]    state_q,    state_d;
    logic [2:0]    active_q,   active_d;
    logic [2:0]    rr_ptr_q,   rr_ptr_d;
    logic [7:0]    csum_q,     csum_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic          empty_q,    empty_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          full;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic          grant_found;
    logic [2:0]    grant_idx;
    logic [3:0]    cand;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_byte;

    // full comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign full    = (count_q == CW'(FIFO_DEPTH));
    // The count guard covers the one cycle where empty_q still shows the pre-pop count.
    assign pop     = tx_buffer_read_enable && !empty_q && (count_q != '0);
    assign g_valid = valid_pad[active_q];
    assign g_last  = last_pad[active_q];
    assign g_byte  = lane_byte[active_q];

    // Round-robin search: first requesting lane at or above rr_ptr, wrapping at NUM_SOURCES.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        cand        = 4'd0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + 4'(k);
            if (cand >= 4'(NUM_SOURCES)) begin
                cand = cand - 4'(NUM_SOURCES);
            end
            if (valid_pad[cand[2:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
    end

    // Ready is offered to the granted lane only, and only while the FIFO has room.
    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_ready
            assign src_ready[gi] = (state_q == ST_PAYLOAD) && !full && (active_q == 3'(gi));
        end
    endgenerate

    // Packet framing FSM: pick a source, push header, payload, then checksum.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        rr_ptr_d  = rr_ptr_q;
        csum_d    = csum_q;
        push      = 1'b0;
        push_data = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    active_d = grant_idx;
                    csum_d   = 8'h00;
                    state_d  = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = HEADER_BASE | {5'b00000, active_q};
                    state_d   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (g_valid && !full) begin
                    push      = 1'b1;
                    push_data = g_byte;
                    csum_d    = csum_q ^ g_byte;
                    if (g_last) begin
                        state_d = ST_CHECKSUM;
                    end
                end
            end
            ST_CHECKSUM: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = csum_q;
                    rr_ptr_d  = (active_q == 3'(NUM_SOURCES - 1)) ? 3'd0 : active_q + 3'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO bookkeeping; the output byte only changes on a real pop.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        out_byte_d = pop  ? mem_q[rd_ptr_q]   : out_byte_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_q == '0);
    end

    // FIFO storage, no reset needed since pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // State registers; reset aborts any packet and flushes the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            active_q   <= 3'd0;
            rr_ptr_q   <= 3'd0;
            csum_q     <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            out_byte_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            rr_ptr_q   <= rr_ptr_d;
            csum_q     <= csum_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            out_byte_q <= out_byte_d;
        end
    end

    assign tx_buffer_empty = empty_q;
    assign tx_buffer_byte  = out_byte_q;
    assign busy            = (state_q != ST_IDLE);
    assign active_source   = active_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: randomized packets per source, compared against a
// packet-level model (round-robin order, header/payload/checksum framing).
module tb_uart_tx_scheduler;

    localparam int         NS = 4;
    localparam logic [7:0] HB = 8'hA0;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NS-1:0]   src_valid = '0;
    logic [8*NS-1:0] src_byte = '0;
    logic [NS-1:0]   src_last = '0;
    logic [NS-1:0]   src_ready;
    logic            tx_buffer_read_enable = 1'b0;
    logic            tx_buffer_empty;
    logic [7:0]      tx_buffer_byte;
    logic            busy;
    logic [2:0]      active_source;

    uart_tx_scheduler #(.NUM_SOURCES(NS), .FIFO_DEPTH(4), .HEADER_BASE(HB)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .src_valid             (src_valid),
        .src_byte              (src_byte),
        .src_last              (src_last),
        .src_ready             (src_ready),
        .tx_buffer_read_enable (tx_buffer_read_enable),
        .tx_buffer_empty       (tx_buffer_empty),
        .tx_buffer_byte        (tx_buffer_byte),
        .busy                  (busy),
        .active_source         (active_source)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Stimulus: per-source byte lists, bit 8 marks the last byte of a packet.
    logic [8:0] lane_mem [NS][256];
    int         lane_wr [NS];
    int         lane_rd [NS];
    // Model state: its own read cursor and round-robin pointer.
    int         m_rd [NS];
    int         m_rr;
    logic [7:0] exp_q [$];
    int         grant_q [$];

    logic [NS-1:0] took = '0;
    bit  pop_pending = 0, popped_last = 0, busy_prev = 0;
    bit  rd_allow = 0, stall_en = 0;
    int  rd_rate = 100;
    int  pops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_byte(input int s, input logic [7:0] b, input bit last);
        lane_mem[s][lane_wr[s]] = {last, b};
        lane_wr[s]++;
    endtask

    task automatic add_rand_packet(input int s, input int len);
        for (int j = 0; j < len; j++) add_byte(s, 8'($urandom), j == len - 1);
    endtask

    // Packet-level reference: next requester from the rr pointer, framed bytes, rr = g+1.
    task automatic model_build();
        int g;
        logic [8:0] e;
        logic [7:0] cs;
        forever begin
            g = -1;
            for (int k = 0; k < NS; k++) begin
                int c;
                c = (m_rr + k) % NS;
                if (g < 0 && m_rd[c] != lane_wr[c]) g = c;
            end
            if (g < 0) break;
            grant_q.push_back(g);
            exp_q.push_back(HB | 8'(g));
            cs = 8'h00;
            do begin
                e = lane_mem[g][m_rd[g]];
                m_rd[g]++;
                exp_q.push_back(e[7:0]);
                cs = cs ^ e[7:0];
            end while (!e[8]);
            exp_q.push_back(cs);
            m_rr = (g + 1) % NS;
        end
    endtask

    // One clock: retire last handshakes/pops, check, drive new inputs, advance to next negedge.
    task automatic step();
        logic [8:0] e;
        bit v, rd;
        for (int i = 0; i < NS; i++) if (took[i]) lane_rd[i]++;
        if (pop_pending) begin
            pops++;
            $display("pop %0d: byte 0x%02h busy=%0b", pops, tx_buffer_byte, busy);
            if (exp_q.size() == 0) check("spurious_pop", {24'h0, tx_buffer_byte}, 32'hFFFF_FFFF);
            else check("pop_byte", {24'h0, tx_buffer_byte}, {24'h0, exp_q.pop_front()});
        end
        if (busy && !busy_prev) begin
            if (grant_q.size() == 0) check("grant_unexpected", 32'(active_source), 32'hFFFF_FFFF);
            else check("grant", 32'(active_source), 32'(grant_q.pop_front()));
        end
        busy_prev = busy;
        for (int i = 0; i < NS; i++) begin
            v = (lane_rd[i] != lane_wr[i]);
            if (v && stall_en && busy && active_source == 3'(i) && $urandom_range(3) == 0) v = 0;
            e = v ? lane_mem[i][lane_rd[i]] : 9'h000;
            src_valid[i]       = v;
            src_byte[8*i +: 8] = e[7:0];
            src_last[i]        = e[8];
            took[i]            = v && src_ready[i];
        end
        rd = rd_allow && !tx_buffer_empty && !popped_last && ($urandom_range(99) < rd_rate);
        tx_buffer_read_enable = rd;
        pop_pending = rd;
        popped_last = rd;
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic bit all_done();
        bit d;
        d = (exp_q.size() == 0) && !busy && !pop_pending;
        for (int i = 0; i < NS; i++) if (lane_rd[i] != lane_wr[i]) d = 0;
        return d;
    endfunction

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        rd_allow = 1;
        while (!all_done() && n < budget) begin
            step();
            n++;
        end
        check("run_completed", 32'(all_done()), 32'd1);
        check("grants_consumed", 32'(grant_q.size()), 32'd0);
        check("idle_after_run", 32'(busy), 32'd0);
    endtask

    task automatic clear_tb_state();
        for (int i = 0; i < NS; i++) begin
            lane_rd[i] = lane_wr[i];
            m_rd[i]    = lane_wr[i];
        end
        exp_q.delete();
        grant_q.delete();
        m_rr = 0;
        took = '0;
        pop_pending = 0;
        popped_last = 0;
        busy_prev = 0;
        src_valid = '0;
        src_last = '0;
        tx_buffer_read_enable = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"},  32'(tx_buffer_empty), 32'd1);
        check({tag, "_byte"},   32'(tx_buffer_byte), 32'h00);
        check({tag, "_ready"},  32'(src_ready), 32'h0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_active"}, 32'(active_source), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        for (int i = 0; i < NS; i++) begin
            lane_wr[i] = 0;
            lane_rd[i] = 0;
            m_rd[i] = 0;
        end
        m_rr = 0;

        // Reset values while held and just after release.
        repeat (3) @(negedge clock);
        check_reset_outputs("reset_held");
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("reset_released");

        // Reads while empty are ignored.
        for (int j = 0; j < 4; j++) begin
            tx_buffer_read_enable = 1'b1;
            @(posedge clock);
            @(negedge clock);
            check("empty_read_byte", 32'(tx_buffer_byte), 32'h00);
            check("empty_read_flag", 32'(tx_buffer_empty), 32'd1);
        end
        tx_buffer_read_enable = 1'b0;

        // Sources 0, 2, 3 with one-byte packets: round-robin 0,2,3,0,2,3...
        for (int r = 0; r < 3; r++) begin
            add_rand_packet(0, 1);
            add_rand_packet(2, 1);
            add_rand_packet(3, 1);
        end
        model_build();
        rd_rate = 100;
        run_until_done(500);

        // Source 1 sends 0x12, 0x34 with a continuous reader; check pipeline latency.
        add_byte(1, 8'h12, 0);
        add_byte(1, 8'h34, 1);
        model_build();
        rd_allow = 1;
        rd_rate = 100;
        step();
        check("lat_busy_edge0", 32'(busy), 32'd1);
        check("lat_empty_edge0", 32'(tx_buffer_empty), 32'd1);
        step();
        check("lat_empty_edge1", 32'(tx_buffer_empty), 32'd1);
        check("lat_no_payload_edge1", 32'(took[1]), 32'd0);
        step();
        check("lat_empty_edge2", 32'(tx_buffer_empty), 32'd0);
        check("lat_payload_edge2", 32'(took[1]), 32'd1);
        run_until_done(200);

        // Idle reader, 6-byte packet on source 0: FIFO fills, then pop with blocked push.
        base = lane_wr[0];
        add_rand_packet(0, 6);
        model_build();
        rd_allow = 0;
        repeat (10) step();
        check("full_ready_low", 32'(src_ready[0]), 32'd0);
        check("full_payload_count", 32'(lane_rd[0] - base), 32'd3);
        check("full_not_empty", 32'(tx_buffer_empty), 32'd0);
        rd_allow = 1;
        rd_rate = 100;
        step();
        check("pop_while_full_frees_slot", 32'(src_ready[0]), 32'd1);
        run_until_done(300);

        // Randomized rounds with stalls and a bursty reader.
        for (int r = 0; r < 6; r++) begin
            bit any;
            any = 0;
            for (int s = 0; s < NS; s++) begin
                if ($urandom_range(1) == 1 || (s == NS - 1 && !any)) begin
                    any = 1;
                    for (int p = 0; p < $urandom_range(3, 1); p++)
                        add_rand_packet(s, $urandom_range(5, 1));
                end
            end
            model_build();
            stall_en = 1;
            rd_rate = $urandom_range(100, 30);
            run_until_done(3000);
        end
        stall_en = 0;

        // Reset in the middle of source 2's payload aborts the packet.
        base = lane_rd[2];
        add_rand_packet(2, 8);
        model_build();
        rd_allow = 0;
        begin
            int n;
            n = 0;
            while (!(busy && active_source == 3'd2 && lane_rd[2] - base >= 2) && n < 50) begin
                step();
                n++;
            end
            check("reached_payload_src2", 32'(n < 50), 32'd1);
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("abort_immediate");
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("abort_next_cycle");
        clear_tb_state();
        reset = 1'b1;
        @(negedge clock);
        add_rand_packet(3, 3);
        model_build();
        rd_rate = 100;
        run_until_done(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
